button_conditioner: RTL and testbench
=====================================

# button_conditioner

Input stage between the board push-buttons and the watch/chronometer state machine. Each raw, bouncing, asynchronous button line is synchronized, debounced and normalized to active-high. The block then outputs a clean level and single-cycle press/release pulses. The mode FSM advances on a press pulse, so it moves exactly once per physical press instead of once per cycle held.

## Interface
- `CLK_HZ`, default 27_000_000: system clock frequency in Hz.
- `DEBOUNCE_MS`, default 20: stability time in ms. `DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS` (540_000 at default).
- `N_BTN`, default 3: number of buttons. Bit 0 = mode (M), bit 1 = start (S), bit 2 = adjust (A).
- `BTN_ACTIVE_LOW`, default 1: 1 means a raw pin reads 0 when pressed.
- `REPEAT_DELAY_MS`, default 500: hold time before the first auto-repeat (only with the macro).
- `REPEAT_RATE_MS`, default 100: auto-repeat period (only with the macro).
- `REPEAT_MASK`, default 3'b100: buttons that auto-repeat (only with the macro).
- `clk  input  1`: system clock, single domain.
- `rst  input  1`: reset, asynchronous, active-high.
- `btn_raw  input  N_BTN`: raw pins, asynchronous to `clk`.
- `btn_level  output  N_BTN`: debounced level, 1 = pressed.
- `btn_press  output  N_BTN`: 1-cycle pulse on each accepted press (and on each auto-repeat).
- `btn_release  output  N_BTN`: 1-cycle pulse on each accepted release.

## Operation
- **Polarity:** each pin is XOR-normalized with `BTN_ACTIVE_LOW`, so 1 = pressed.
- **Synchronizer:** 2-FF per bit. Registers reset to the released value (0 after normalization), so no press is seen coming out of reset.
- **Per-button debounce state:** `stable` (1 bit) and `cnt` (width `$clog2(DB_CYCLES)`).
  - Synchronized value equals `stable`: `cnt` is cleared to 0.
  - Values differ and `cnt < DB_CYCLES-1`: `cnt` increments.
  - Values differ and `cnt == DB_CYCLES-1`: `stable` toggles and `cnt` clears.
- **Glitches:** a mismatch shorter than `DB_CYCLES` consecutive cycles clears `cnt` and produces no output.
- **Outputs:**
  - `btn_level` is `stable`, registered.
  - `btn_press` is high in the cycle `stable` goes 0→1.
  - `btn_release` is high in the cycle `stable` goes 1→0.
  - All outputs are registers, never combinational from `btn_raw`.
- **Independence:** buttons do not interact. Presses on several buttons in the same cycle all pulse in that cycle. No priority or masking.
- **Reset:**
  - `btn_level`, `btn_press`, `btn_release`, all `cnt` and all `stable` = 0.
  - Reset asserted mid-debounce discards the partial count.
  - After deassertion, a button held through reset is reported as a press after 2+`DB_CYCLES` cycles.

## Timing
- Raw edge to `btn_level` change: 2 synchronizer cycles + `DB_CYCLES` cycles. Total 2+`DB_CYCLES` clocks after the first `clk` edge that samples the new value.
- `btn_press` and `btn_release` are exactly 1 cycle wide, coincident with the `btn_level` edge.
- A press followed by a release yields exactly one press pulse and one release pulse, at least `DB_CYCLES` cycles apart.
- Minimum accepted pulse width (pressed or released): `DB_CYCLES` cycles. Anything shorter is filtered.

## Configuration
- **Macro `BTN_REPEAT_EN`:** when defined, each button in `REPEAT_MASK` gets a hold counter.
  - First extra `btn_press` pulse fires `REPEAT_DELAY` cycles after the initial press pulse.
  - Further pulses fire every `REPEAT_RATE` cycles while `btn_level` stays 1.
  - Release or reset clears the hold counter immediately; no pulse is emitted in the release cycle.
- **Without the macro:** the hold counters are not built. Exactly one `btn_press` per accepted press, regardless of hold time; `REPEAT_*` parameters are ignored.

## Structure
- **Package `watch_pkg`:**
  - Button index constants `BTN_MODE=0`, `BTN_START=1`, `BTN_ADJUST=2`.
  - Constant function `ms_to_cycles(clk_hz, ms)`.
  - Shared with the mode FSM.
- **Sub-module `debounce_cell`:** one instance per button via a generate loop. Each instance contains the synchronizer, `stable`/`cnt`, edge pulses and, under the macro, the repeat counter. The top level is only polarity normalization and the generate loop.

## Test plan
Bench parameters: `CLK_HZ=1000`, `DEBOUNCE_MS=4` (`DB_CYCLES=4`), `REPEAT_DELAY_MS=10`, `REPEAT_RATE_MS=3`, `BTN_ACTIVE_LOW=1`.

- **Reset:** hold `rst` high with `btn_raw=3'b111` (all released) → all outputs 0. Assert `rst` asynchronously mid-cycle → outputs clear without waiting for a `clk` edge.
- **Clean press:** drive `btn_raw[0]` low and hold → `btn_level[0]` rises 6 cycles later, with `btn_press[0]` high for exactly that 1 cycle. Release → `btn_release[0]` pulses once, 6 cycles after the raw edge.
- **Bounce filter:** toggle `btn_raw[1]` low for 3 cycles, high for 1, low for 2, then high → no output activity. Then hold low for 4 or more cycles → exactly one `btn_press[1]`.
- **Simultaneous:** drive `btn_raw[0]` and `btn_raw[2]` low in the same cycle → `btn_press` = 3'b101 in a single cycle, no other pulses.
- **Reset mid-debounce:** button low for 3 cycles, pulse `rst`, keep the button low → press pulse arrives 6 cycles after `rst` deasserts, not earlier.
- **With `BTN_REPEAT_EN`:** hold adjust for 30 cycles → `btn_press[2]` at the initial edge, then +10 cycles, then every 3 cycles; no repeats after release. Hold mode for 30 cycles → exactly one `btn_press[0]`, since mode is not in `REPEAT_MASK`.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared constants and helpers for the watch/chronometer front end and mode FSM.
// Optional auto-repeat in the button path is enabled with the BTN_REPEAT_EN macro.
package watch_pkg;

    typedef enum int {
        BTN_MODE   = 0,
        BTN_START  = 1,
        BTN_ADJUST = 2
    } btn_idx_e;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: 2-FF synchronizer, stability counter, registered level and edge pulses.
// With BTN_REPEAT_EN defined, a hold counter adds auto-repeat press pulses.
module debounce_cell
    import watch_pkg::*;
#(
    parameter int DB_CYCLES    = 4
`ifdef BTN_REPEAT_EN
    ,
    parameter bit REPEAT_EN    = 1'b0,
    parameter int REPEAT_DELAY = 10,
    parameter int REPEAT_RATE  = 3
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int                 CNT_W    = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, press_q, release_q;
    logic             repeat_fire;

    // Any cycle where the synchronized value matches stable restarts the window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int               RPT_W     = cnt_width((REPEAT_DELAY > REPEAT_RATE) ?
                                                       REPEAT_DELAY : REPEAT_RATE);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_RATE - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             held;

    // Held means already reported and still debounced pressed; releasing drops it at once.
    assign held = stable_q & level_q;

    always_comb begin
        rpt_d       = RPT_FIRST;
        repeat_fire = 1'b0;
        if (held) begin
            if (rpt_q == '0) begin
                repeat_fire = REPEAT_EN;
                rpt_d       = RPT_NEXT;
            end else begin
                rpt_d = rpt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q <= RPT_FIRST;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            stable_q  <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], pin_i};
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            level_q   <= stable_q;
            press_q   <= (stable_q & ~level_q) | repeat_fire;
            release_q <= ~stable_q & level_q;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: polarity normalization plus one debounce_cell per button.
// Define BTN_REPEAT_EN to build auto-repeat for the buttons in REPEAT_MASK.
module button_conditioner
    import watch_pkg::*;
#(
    parameter int               CLK_HZ          = 27_000_000,
    parameter int               DEBOUNCE_MS     = 20,
    parameter int               N_BTN           = 3,
    parameter bit               BTN_ACTIVE_LOW  = 1'b1,
    parameter int               REPEAT_DELAY_MS = 500,
    parameter int               REPEAT_RATE_MS  = 100,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(1 << int'(BTN_ADJUST))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam int DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);

    logic [N_BTN-1:0] pin_norm;

    assign pin_norm = btn_raw ^ {N_BTN{BTN_ACTIVE_LOW}};

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
`ifdef BTN_REPEAT_EN
            debounce_cell #(
                .DB_CYCLES    (DB_CYCLES),
                .REPEAT_EN    (REPEAT_MASK[gi]),
                .REPEAT_DELAY (ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS)),
                .REPEAT_RATE  (ms_to_cycles(CLK_HZ, REPEAT_RATE_MS))
            ) u_cell (
                .clk       (clk),
                .rst       (rst),
                .pin_i     (pin_norm[gi]),
                .level_o   (btn_level[gi]),
                .press_o   (btn_press[gi]),
                .release_o (btn_release[gi])
            );
`else
            debounce_cell #(
                .DB_CYCLES (DB_CYCLES)
            ) u_cell (
                .clk       (clk),
                .rst       (rst),
                .pin_i     (pin_norm[gi]),
                .level_o   (btn_level[gi]),
                .press_o   (btn_press[gi]),
                .release_o (btn_release[gi])
            );
`endif
        end
    endgenerate

`ifndef BTN_REPEAT_EN
    logic [N_BTN-1:0] unused_repeat_cfg;
    assign unused_repeat_cfg = REPEAT_MASK ^ N_BTN'(REPEAT_DELAY_MS ^ REPEAT_RATE_MS);
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner against a run-length reference model.
// Repeat scenarios are included when BTN_REPEAT_EN is defined.
module tb_button_conditioner;

    localparam int DB  = 4;
    localparam int LAT = 2 + DB;
`ifdef BTN_REPEAT_EN
    localparam int         RPT_DELAY = 10;
    localparam int         RPT_RATE  = 3;
    localparam logic [2:0] RPT_MASK  = 3'b100;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn_raw = 3'b111;
    logic [2:0] btn_level, btn_press, btn_release;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .CLK_HZ          (1000),
        .DEBOUNCE_MS     (4),
        .N_BTN           (3),
        .BTN_ACTIVE_LOW  (1'b1),
        .REPEAT_DELAY_MS (10),
        .REPEAT_RATE_MS  (3),
        .REPEAT_MASK     (3'b100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    // Reference: a level flips once DB consecutive pressed-view samples, seen through a
    // 3-edge delay line, disagree with it; press/release mark the flip edge.
    logic [2:0] h0, h1, h2;
    int         run_q  [3];
    int         hold_q [3];
    logic [2:0] exp_level, exp_press, exp_release;

    always @(posedge clk or posedge rst) begin : model
        logic [2:0] d, lvl, pr, rl;
        int         r [3];
        int         h [3];
        if (rst) begin
            h0 <= '0; h1 <= '0; h2 <= '0;
            exp_level <= '0; exp_press <= '0; exp_release <= '0;
            for (int b = 0; b < 3; b++) begin
                run_q[b]  <= 0;
                hold_q[b] <= 0;
            end
        end else begin
            d = h0; lvl = exp_level; pr = '0; rl = '0;
            for (int b = 0; b < 3; b++) begin
                r[b] = (d[b] != lvl[b]) ? run_q[b] + 1 : 0;
                h[b] = hold_q[b];
                if (r[b] == DB) begin
                    r[b]   = 0;
                    lvl[b] = ~lvl[b];
                    h[b]   = 0;
                    if (lvl[b]) pr[b] = 1'b1;
                    else        rl[b] = 1'b1;
                end else if (lvl[b]) begin
                    h[b] = hold_q[b] + 1;
`ifdef BTN_REPEAT_EN
                    if (RPT_MASK[b] && (h[b] == RPT_DELAY ||
                        (h[b] > RPT_DELAY && (h[b] - RPT_DELAY) % RPT_RATE == 0)))
                        pr[b] = 1'b1;
`endif
                end
                run_q[b]  <= r[b];
                hold_q[b] <= h[b];
            end
            h0 <= h1; h1 <= h2; h2 <= ~btn_raw;
            exp_level <= lvl; exp_press <= pr; exp_release <= rl;
        end
    end

    task automatic test_reset();
        rst = 1'b1; btn_raw = 3'b111;
        repeat (3) @(negedge clk);
        vectors++;
        if ({btn_level, btn_press, btn_release} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got lvl=%b prs=%b rel=%b want all 0", btn_level, btn_press, btn_release);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({btn_level, btn_press, btn_release} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got lvl=%b prs=%b rel=%b want all 0", btn_level, btn_press, btn_release);
        end
    endtask

    task automatic test_clean_press();
        btn_raw = 3'b110;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if ({btn_level[0], btn_press[0], btn_release[0]} !== {k >= LAT, k == LAT, 1'b0}) begin
                miscompares++;
                $display("FAIL clean_press k=%0d: got lvl/prs/rel=%b%b%b want %b%b%b", k,
                         btn_level[0], btn_press[0], btn_release[0], k >= LAT, k == LAT, 1'b0);
            end
        end
        btn_raw = 3'b111;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if ({btn_level[0], btn_press[0], btn_release[0]} !== {k < LAT, 1'b0, k == LAT}) begin
                miscompares++;
                $display("FAIL clean_release k=%0d: got lvl/prs/rel=%b%b%b want %b%b%b", k,
                         btn_level[0], btn_press[0], btn_release[0], k < LAT, 1'b0, k == LAT);
            end
        end
    endtask

    task automatic test_async_reset();
        btn_raw = 3'b110;
        repeat (LAT + 3) @(negedge clk);
        vectors++;
        if (btn_level !== 3'b001) begin
            miscompares++;
            $display("FAIL async_setup: got lvl=%b want 001", btn_level);
        end
        #2 rst = 1'b1; btn_raw = 3'b111;
        #1;
        vectors++;
        if ({btn_level, btn_press, btn_release} !== 9'b0) begin
            miscompares++;
            $display("FAIL async_reset: got lvl=%b prs=%b rel=%b want all 0 before clk edge", btn_level, btn_press, btn_release);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bounce();
        logic seq [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int   presses = 0;
        for (int i = 0; i < 12; i++) begin
            btn_raw = {1'b1, seq[i], 1'b1};
            @(negedge clk);
            vectors++;
            if ({btn_level, btn_press, btn_release} !== 9'b0 ||
                {exp_level, exp_press, exp_release} !== 9'b0) begin
                miscompares++;
                $display("FAIL bounce i=%0d: got lvl=%b prs=%b rel=%b model %b/%b/%b want all 0", i,
                         btn_level, btn_press, btn_release, exp_level, exp_press, exp_release);
            end
        end
        btn_raw = 3'b101;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (btn_press[1]) presses++;
        end
        vectors++;
        if (presses !== 1) begin
            miscompares++;
            $display("FAIL bounce_hold: got %0d press pulses want 1", presses);
        end
        btn_raw = 3'b111;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int pulses = 0;
        btn_raw = 3'b010;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (btn_press != 3'b000 || btn_release != 3'b000) begin
                pulses++;
                vectors++;
                if (btn_press !== 3'b101 || btn_release !== 3'b000 || k != LAT) begin
                    miscompares++;
                    $display("FAIL simultaneous k=%0d: got prs=%b rel=%b want prs=101 rel=000 at k=%0d", k, btn_press, btn_release, LAT);
                end
            end
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL simultaneous_count: got %0d pulse cycles want 1", pulses);
        end
        btn_raw = 3'b111;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic test_reset_mid_debounce();
        btn_raw = 3'b110;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if ({btn_level[0], btn_press[0]} !== {k >= LAT, k == LAT}) begin
                miscompares++;
                $display("FAIL reset_mid_db k=%0d: got lvl/prs=%b%b want %b%b", k,
                         btn_level[0], btn_press[0], k >= LAT, k == LAT);
            end
        end
        btn_raw = 3'b111;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic test_random();
        int left [3] = '{0, 0, 0};
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (left[b] == 0) begin
                    btn_raw[b] = ($urandom_range(0, 2) != 0) ? ~btn_raw[b] : btn_raw[b];
                    left[b]    = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 24) : $urandom_range(1, 6);
                end
                left[b]--;
            end
            @(negedge clk);
            vectors++;
            if ({btn_level, btn_press, btn_release} !== {exp_level, exp_press, exp_release}) begin
                miscompares++;
                $display("FAIL random c=%0d raw=%b: got lvl=%b prs=%b rel=%b want %b/%b/%b", c, btn_raw,
                         btn_level, btn_press, btn_release, exp_level, exp_press, exp_release);
            end
        end
        btn_raw = 3'b111;
        for (int c = 0; c < LAT + 4; c++) begin
            @(negedge clk);
            vectors++;
            if ({btn_level, btn_press, btn_release} !== {exp_level, exp_press, exp_release}) begin
                miscompares++;
                $display("FAIL random_settle c=%0d: got lvl=%b prs=%b rel=%b want %b/%b/%b", c,
                         btn_level, btn_press, btn_release, exp_level, exp_press, exp_release);
            end
        end
    endtask

`ifdef BTN_REPEAT_EN
    task automatic test_repeat();
        int   presses = 0;
        logic want;
        btn_raw = 3'b011;
        for (int k = 0; k < 45; k++) begin
            if (k == 30) btn_raw = 3'b111;
            @(negedge clk);
            want = (k == LAT) || (k >= LAT + RPT_DELAY && k <= 34 && (k - LAT - RPT_DELAY) % RPT_RATE == 0);
            vectors++;
            if (btn_press[2] !== want || btn_press !== exp_press) begin
                miscompares++;
                $display("FAIL repeat_adjust k=%0d: got prs=%b want bit2=%b model=%b", k, btn_press, want, exp_press);
            end
        end
        btn_raw = 3'b110;
        for (int k = 0; k < 45; k++) begin
            if (k == 30) btn_raw = 3'b111;
            @(negedge clk);
            if (btn_press[0]) presses++;
        end
        vectors++;
        if (presses !== 1) begin
            miscompares++;
            $display("FAIL repeat_mode: got %0d press pulses want 1", presses);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_async_reset();
        test_bounce();
        test_simultaneous();
        test_reset_mid_debounce();
        test_random();
`ifdef BTN_REPEAT_EN
        test_repeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
